// File: rtl/midi_parser_pkg.sv
// Shared MIDI types: parsed message layout, channel message types and
// the system byte boundaries the parser classifies against.
package midi_parser_pkg;

  typedef enum logic [3:0] {
    NOTE_OFF         = 4'h8,
    NOTE_ON          = 4'h9,
    POLY_PRESSURE    = 4'hA,
    CONTROL_CHANGE   = 4'hB,
    PROGRAM_CHANGE   = 4'hC,
    CHANNEL_PRESSURE = 4'hD,
    PITCH_BEND       = 4'hE
  } msg_type_e;

  // message_type is plain logic so the all-zero reset value stays legal.
  typedef struct packed {
    logic [3:0] message_type;
    logic [3:0] channel;
    logic [7:0] data_byte1;
    logic [7:0] data_byte2;
  } message_t;

  localparam logic [7:0] SYSEX_START  = 8'hF0;
  localparam logic [7:0] SYSEX_END    = 8'hF7;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2,
    SYSEX   = 2'd3
  } state_e;

  function automatic logic one_data_byte(input logic [3:0] t);
    return (t == PROGRAM_CHANGE) || (t == CHANNEL_PRESSURE);
  endfunction

endpackage

// File: rtl/midi_parser.sv
// MIDI channel-message parser: status/running-status FSM fed by a UART byte
// strobe, producing one registered message pulse per completed message.
module midi_parser
  import midi_parser_pkg::*;
#(
  parameter int         OMNI    = 1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clock_50_000_000,
  input  logic       reset_l,
  input  logic [7:0] rx_byte,
  input  logic       rx_byte_ready,
  output message_t   message,
  output logic       message_ready,
  output logic       parse_error
);

  state_e     r_state, w_next_state;
  logic [3:0] r_type, r_chan;
  logic [7:0] r_d1;
  message_t   r_msg;
  logic       r_msg_ready, r_parse_err;

  logic       w_lat_status, w_lat_d1, w_emit, w_err, w_deliver;
  logic [7:0] w_d1, w_d2;
  message_t   w_msg;

  always_comb begin
    w_next_state = r_state;
    w_lat_status = 1'b0;
    w_lat_d1     = 1'b0;
    w_emit       = 1'b0;
    w_err        = 1'b0;
    w_d1         = r_d1;
    w_d2         = 8'h00;
    if (rx_byte_ready) begin
      if (rx_byte >= REALTIME_MIN) begin
        w_next_state = r_state;
      end else if (rx_byte[7] && (rx_byte < SYSEX_START)) begin
        w_lat_status = 1'b1;
        w_next_state = WAIT_D1;
      end else if (rx_byte == SYSEX_START) begin
        w_next_state = SYSEX;
      end else if (rx_byte[7]) begin
        // 0xF1-0xF7: ends SYSEX, and anywhere else drops running status.
        w_next_state = IDLE;
      end else begin
        case (r_state)
          IDLE:    w_err = 1'b1;
          WAIT_D1: begin
            w_lat_d1 = 1'b1;
            if (one_data_byte(r_type)) begin
              w_emit = 1'b1;
              w_d1   = rx_byte;
            end else begin
              w_next_state = WAIT_D2;
            end
          end
          WAIT_D2: begin
            w_emit       = 1'b1;
            w_d2         = rx_byte;
            w_next_state = WAIT_D1;
          end
          default: w_next_state = r_state;
        endcase
      end
    end
  end

  always_comb begin
    w_msg.message_type = ((r_type == NOTE_ON) && (w_d2 == 8'h00)) ? NOTE_OFF : r_type;
    w_msg.channel      = r_chan;
    w_msg.data_byte1   = w_d1;
    w_msg.data_byte2   = w_d2;
    w_deliver          = w_emit && ((OMNI != 0) || (r_chan == CHANNEL));
  end

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      r_state     <= IDLE;
      r_type      <= 4'h0;
      r_chan      <= 4'h0;
      r_d1        <= 8'h00;
      r_msg       <= '0;
      r_msg_ready <= 1'b0;
      r_parse_err <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_msg_ready <= w_deliver;
      r_parse_err <= w_err;
      if (w_lat_status) begin
        r_type <= rx_byte[7:4];
        r_chan <= rx_byte[3:0];
      end
      if (w_lat_d1) r_d1 <= rx_byte;
      // Filtered-out channels leave the last delivered message on the port.
      if (w_deliver) r_msg <= w_msg;
    end
  end

  assign message       = r_msg;
  assign message_ready = r_msg_ready;
  assign parse_error   = r_parse_err;

endmodule

// File: tb/tb_midi_parser.sv
// Directed bench for midi_parser: an omni instance and a channel-2 filtered
// instance share one byte stream; expected messages are hand-computed.
module tb_midi_parser;
  import midi_parser_pkg::*;

  logic       gclk = 1'b0;
  logic       grst_n = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_rdy = 1'b0;

  message_t   om_msg, ch_msg;
  logic       om_rdy, om_err, ch_rdy, ch_err;

  int checks = 0;
  int errors = 0;

  always #5 gclk = ~gclk;

  midi_parser #(.OMNI(1), .CHANNEL(4'd0)) u_omni (
    .clock_50_000_000(gclk), .reset_l(grst_n), .rx_byte(rx_byte),
    .rx_byte_ready(rx_rdy), .message(om_msg), .message_ready(om_rdy),
    .parse_error(om_err)
  );

  midi_parser #(.OMNI(0), .CHANNEL(4'd2)) u_ch2 (
    .clock_50_000_000(gclk), .reset_l(grst_n), .rx_byte(rx_byte),
    .rx_byte_ready(rx_rdy), .message(ch_msg), .message_ready(ch_rdy),
    .parse_error(ch_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Strobe one byte; on return (next negedge) outputs reflect that byte.
  task automatic put(input logic [7:0] b);
    rx_byte = b;
    rx_rdy  = 1'b1;
    @(negedge gclk);
  endtask

  task automatic idle();
    rx_rdy = 1'b0;
    @(negedge gclk);
  endtask

  // Byte produced no pulse on the omni instance.
  task automatic quiet(input string tag);
    chk({tag, "_rdy"}, {31'd0, om_rdy}, 32'd0);
    chk({tag, "_err"}, {31'd0, om_err}, 32'd0);
  endtask

  task automatic emit(input string tag, input logic [23:0] m);
    chk({tag, "_rdy"}, {31'd0, om_rdy}, 32'd1);
    chk({tag, "_msg"}, {8'd0, om_msg}, {8'd0, m});
  endtask

  initial begin
    repeat (2) @(negedge gclk);
    chk("rst_msg", {8'd0, om_msg}, 32'd0);
    chk("rst_rdy", {31'd0, om_rdy}, 32'd0);
    chk("rst_err", {31'd0, om_err}, 32'd0);
    chk("rst_ch_msg", {8'd0, ch_msg}, 32'd0);
    grst_n = 1'b1;
    @(negedge gclk);

    // Basic note on; channel 0 is filtered by the channel-2 instance
    put(8'h90); quiet("n1_s");
    put(8'h3C); quiet("n1_d1");
    put(8'h64); emit("n1", 24'h903C64);
    chk("n1_ch_rdy", {31'd0, ch_rdy}, 32'd0);
    idle();     quiet("n1_after");

    // Running status and velocity-0 to NOTE_OFF
    put(8'h91); put(8'h40);
    put(8'h7F); emit("rs1", 24'h91407F);
    put(8'h41); quiet("rs_mid");
    put(8'h00); emit("rs2", 24'h814100);
    idle();     quiet("rs_after");

    // Realtime byte inside a message
    put(8'h90); put(8'h3C);
    put(8'hF8); quiet("rt_f8");
    put(8'h50); emit("rt", 24'h903C50);
    idle();

    // SysEx payload ignored, data after F7 is stray
    put(8'hF0); quiet("sx_f0");
    put(8'h12); quiet("sx_d1");
    put(8'h34); quiet("sx_d2");
    put(8'hF7); quiet("sx_f7");
    put(8'h40);
    chk("sx_stray_err", {31'd0, om_err}, 32'd1);
    chk("sx_stray_rdy", {31'd0, om_rdy}, 32'd0);
    idle();
    chk("sx_err_pulse", {31'd0, om_err}, 32'd0);

    // Channel filter: ch3 suppressed, ch2 delivered
    put(8'h93); put(8'h3C); put(8'h64);
    chk("flt3_rdy", {31'd0, ch_rdy}, 32'd0);
    emit("flt3_omni", 24'h933C64);
    put(8'h92); put(8'h3C); put(8'h64);
    chk("flt2_rdy", {31'd0, ch_rdy}, 32'd1);
    chk("flt2_msg", {8'd0, ch_msg}, {8'd0, 24'h923C64});
    idle();
    chk("flt2_hold", {8'd0, ch_msg}, {8'd0, 24'h923C64});

    // New status discards a partial message
    put(8'h90); put(8'h3C);
    put(8'h80); put(8'h10);
    put(8'h20); emit("abort", 24'h801020);
    idle();

    // Pitch bend (two-byte type with zero first data byte)
    put(8'hE5); put(8'h00);
    put(8'h40); emit("pb", 24'hE50040);
    idle();

    // System common clears running status
    put(8'hF3);
    put(8'h10);
    chk("sc_stray_err", {31'd0, om_err}, 32'd1);
    idle();

    // Program change: one data byte, running status, d2 = 0
    put(8'hC0);
    put(8'h05); emit("pc1", 24'hC00500);
    put(8'h07); emit("pc2", 24'hC00700);
    put(8'h90); put(8'h3C);
    idle();
    #2 grst_n = 1'b0;
    #1;
    chk("arst_msg", {8'd0, om_msg}, 32'd0);
    chk("arst_rdy", {31'd0, om_rdy}, 32'd0);
    @(negedge gclk);
    grst_n = 1'b1;
    put(8'h64);
    chk("post_rst_rdy", {31'd0, om_rdy}, 32'd0);
    chk("post_rst_err", {31'd0, om_err}, 32'd1);
    chk("post_rst_msg", {8'd0, om_msg}, 32'd0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
